// File: rtl/excp_pkg.sv
// Shared definitions for the commit-stage exception initiator: cause codes,
// commit_excp bit positions and the controller state encoding.
package excp_pkg;

  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;

  localparam logic [8:0] ESUB_NONE = 9'd0;
  localparam logic [8:0] ESUB_ADEF = 9'd0;
  localparam logic [8:0] ESUB_ADEM = 9'd1;

  localparam int EXCP_ADEF = 0;
  localparam int EXCP_INE  = 1;
  localparam int EXCP_SYS  = 2;
  localparam int EXCP_BRK  = 3;
  localparam int EXCP_ALE  = 4;
  localparam int EXCP_ADEM = 5;
  localparam int EXCP_RSVD = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } excp_state_t;

endpackage

// File: rtl/excp_prio_enc.sv
// Fixed-priority cause selection: interrupt first, then the commit exception
// flags in architectural order. ERTN is resolved by the caller when hit=0.
module excp_prio_enc
  import excp_pkg::*;
(
  input  logic       has_int,
  input  logic [5:0] excp,
  output logic       hit,
  output logic [5:0] ecode,
  output logic [8:0] esubcode
);

  always_comb begin
    hit      = 1'b1;
    ecode    = ECODE_INT;
    esubcode = ESUB_NONE;
    if (has_int) begin
      ecode = ECODE_INT;
    end else if (excp[EXCP_ADEF]) begin
      ecode    = ECODE_ADE;
      esubcode = ESUB_ADEF;
    end else if (excp[EXCP_INE]) begin
      ecode = ECODE_INE;
    end else if (excp[EXCP_SYS]) begin
      ecode = ECODE_SYS;
    end else if (excp[EXCP_BRK]) begin
      ecode = ECODE_BRK;
    end else if (excp[EXCP_ALE]) begin
      ecode = ECODE_ALE;
    end else if (excp[EXCP_ADEM]) begin
      ecode    = ECODE_ADE;
      esubcode = ESUB_ADEM;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/excp_commit_ctrl.sv
// Commit-stage exception/ERTN initiator: one-cycle flush pulse, then a held
// redirect to fetch. Optional BADV capture is enabled with `define EXCP_BADV_EN.
module excp_commit_ctrl
  import excp_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int EENTRY_ALIGN = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            commit_valid,
  input  logic [PC_W-1:0] commit_pc,
  input  logic [6:0]      commit_excp,
  input  logic            commit_ertn,
  input  logic            has_int,
  input  logic [PC_W-1:0] csr_eentry,
  input  logic [PC_W-1:0] csr_era,
`ifdef EXCP_BADV_EN
  input  logic [PC_W-1:0] commit_vaddr,
  output logic            badv_we,
  output logic [PC_W-1:0] badv_out,
`endif
  output logic            excp_flush,
  output logic            ertn_flush,
  output logic [5:0]      ecode_out,
  output logic [8:0]      esubcode_out,
  output logic [PC_W-1:0] era_out,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            commit_stall
);

  excp_state_t     state, next_state;
  logic            prio_hit;
  logic [5:0]      prio_ecode;
  logic [8:0]      prio_esub;
  logic            trigger;
  logic            ertn_q;
  logic [PC_W-1:0] target_d;
  logic            unused_bits;

  excp_prio_enc u_prio (
    .has_int  (has_int),
    .excp     (commit_excp[5:0]),
    .hit      (prio_hit),
    .ecode    (prio_ecode),
    .esubcode (prio_esub)
  );

  assign unused_bits = ^{commit_excp[EXCP_RSVD], csr_eentry[EENTRY_ALIGN-1:0]};
  assign trigger     = commit_valid & (prio_hit | commit_ertn);
  assign target_d    = prio_hit ? {csr_eentry[PC_W-1:EENTRY_ALIGN], {EENTRY_ALIGN{1'b0}}}
                                : csr_era;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (trigger) next_state = ST_FLUSH;
      ST_FLUSH: next_state = ST_REDIR;
      ST_REDIR: if (redirect_ready) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Cause fields only move on an exception so an ERTN leaves the last values visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      ertn_q       <= 1'b0;
      redirect_pc  <= '0;
      ecode_out    <= '0;
      esubcode_out <= '0;
      era_out      <= '0;
    end else if (state == ST_IDLE && trigger) begin
      ertn_q      <= ~prio_hit;
      redirect_pc <= target_d;
      if (prio_hit) begin
        ecode_out    <= prio_ecode;
        esubcode_out <= prio_esub;
        era_out      <= commit_pc;
      end
    end
  end

`ifdef EXCP_BADV_EN
  logic badv_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      badv_q   <= 1'b0;
      badv_out <= '0;
    end else if (state == ST_IDLE && trigger) begin
      badv_q <= prio_hit & ((prio_ecode == ECODE_ADE) | (prio_ecode == ECODE_ALE));
      if (prio_hit && prio_ecode == ECODE_ADE && prio_esub == ESUB_ADEF)
        badv_out <= commit_pc;
      else if (prio_hit && (prio_ecode == ECODE_ALE || prio_ecode == ECODE_ADE))
        badv_out <= commit_vaddr;
    end
  end

  assign badv_we = (state == ST_FLUSH) & badv_q & ~reset;
`endif

  // Pulses are suppressed while reset is high so an aborted sequence emits nothing.
  always_comb begin
    excp_flush     = 1'b0;
    ertn_flush     = 1'b0;
    redirect_valid = 1'b0;
    commit_stall   = 1'b0;
    case (state)
      ST_IDLE: commit_stall = trigger & ~reset;
      ST_FLUSH: begin
        excp_flush   = ~ertn_q & ~reset;
        ertn_flush   = ertn_q & ~reset;
        commit_stall = ~reset;
      end
      ST_REDIR: begin
        redirect_valid = ~reset;
        commit_stall   = ~reset;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// Self-checking bench for excp_commit_ctrl: directed scenarios plus random
// transactions compared against a transaction-level cause/target model.
module tb_excp_commit_ctrl;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            commit_valid;
  logic [PC_W-1:0] commit_pc;
  logic [6:0]      commit_excp;
  logic            commit_ertn;
  logic            has_int;
  logic [PC_W-1:0] csr_eentry;
  logic [PC_W-1:0] csr_era;
  logic            excp_flush;
  logic            ertn_flush;
  logic [5:0]      ecode_out;
  logic [8:0]      esubcode_out;
  logic [PC_W-1:0] era_out;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            redirect_ready;
  logic            commit_stall;
`ifdef EXCP_BADV_EN
  logic [PC_W-1:0] commit_vaddr;
  logic            badv_we;
  logic [PC_W-1:0] badv_out;
`endif

  int total = 0;
  int bad   = 0;

  logic [5:0]      last_ec;
  logic [8:0]      last_es;
  logic [PC_W-1:0] last_era;

  excp_commit_ctrl #(.PC_W(PC_W), .EENTRY_ALIGN(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .commit_excp    (commit_excp),
    .commit_ertn    (commit_ertn),
    .has_int        (has_int),
    .csr_eentry     (csr_eentry),
    .csr_era        (csr_era),
`ifdef EXCP_BADV_EN
    .commit_vaddr   (commit_vaddr),
    .badv_we        (badv_we),
    .badv_out       (badv_out),
`endif
    .excp_flush     (excp_flush),
    .ertn_flush     (ertn_flush),
    .ecode_out      (ecode_out),
    .esubcode_out   (esubcode_out),
    .era_out        (era_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .commit_stall   (commit_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    commit_valid   = 1'b0;
    commit_pc      = '0;
    commit_excp    = '0;
    commit_ertn    = 1'b0;
    has_int        = 1'b0;
    csr_eentry     = '0;
    csr_era        = '0;
    redirect_ready = 1'b0;
`ifdef EXCP_BADV_EN
    commit_vaddr   = '0;
`endif
  endtask

  // Busy cycles get random commits; the controller must ignore all of them.
  task automatic garbage();
    commit_valid = 1'($urandom_range(0, 1));
    commit_pc    = $urandom;
    commit_excp  = 7'($urandom);
    commit_ertn  = 1'($urandom_range(0, 1));
    has_int      = 1'($urandom_range(0, 1));
    csr_eentry   = $urandom;
    csr_era      = $urandom;
`ifdef EXCP_BADV_EN
    commit_vaddr = $urandom;
`endif
  endtask

  // Reference: interrupt wins, then flag bits 0..5 in ascending order, then ERTN.
  function automatic void model(input logic hi, input logic [6:0] ex, input logic er,
                                output bit trig, output bit only_ertn,
                                output logic [5:0] ec, output logic [8:0] es,
                                output int first_bit);
    logic [5:0] codes [6];
    logic [8:0] subs  [6];
    codes = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09, 6'h08};
    subs  = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd1};
    trig = 1'b0; only_ertn = 1'b0; ec = '0; es = '0; first_bit = -1;
    if (hi) begin
      trig = 1'b1;
      return;
    end
    for (int i = 0; i < 6; i++) begin
      if (ex[i]) begin
        trig = 1'b1; ec = codes[i]; es = subs[i]; first_bit = i;
        return;
      end
    end
    if (er) begin
      trig = 1'b1; only_ertn = 1'b1;
    end
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_xf"}, 32'(excp_flush), 32'd0);
    check({tag, "_ef"}, 32'(ertn_flush), 32'd0);
    check({tag, "_ec"}, 32'(ecode_out), 32'd0);
    check({tag, "_es"}, 32'(esubcode_out), 32'd0);
    check({tag, "_era"}, era_out, 32'd0);
    check({tag, "_rv"}, 32'(redirect_valid), 32'd0);
    check({tag, "_rpc"}, redirect_pc, 32'd0);
    check({tag, "_stall"}, 32'(commit_stall), 32'd0);
`ifdef EXCP_BADV_EN
    check({tag, "_bwe"}, 32'(badv_we), 32'd0);
`endif
  endtask

  task automatic apply_stimulus(input logic [31:0] pc, input logic [6:0] ex, input logic er,
                                input logic hi, input logic [31:0] ee, input logic [31:0] ea,
                                input logic [31:0] va, input int delay);
    bit trig, only_ertn;
    logic [5:0] ec;
    logic [8:0] es;
    int fb;
    logic [31:0] tgt;
    model(hi, ex, er, trig, only_ertn, ec, es, fb);
    tgt = only_ertn ? ea : (ee & 32'hFFFF_FFC0);

    tick();
    commit_valid = 1'b1; commit_pc = pc; commit_excp = ex; commit_ertn = er;
    has_int = hi; csr_eentry = ee; csr_era = ea;
    redirect_ready = 1'($urandom_range(0, 1));
`ifdef EXCP_BADV_EN
    commit_vaddr = va;
`else
    if (va == 32'hDEAD_BEEF) $display("[TB] vaddr unused in this build");
`endif
    sample();
    check("trig_stall", 32'(commit_stall), 32'(trig));
    check("trig_noflush", 32'(excp_flush | ertn_flush), 32'd0);

    if (!trig) begin
      tick();
      idle_inputs();
      sample();
      check("notrig_xf", 32'(excp_flush), 32'd0);
      check("notrig_ef", 32'(ertn_flush), 32'd0);
      check("notrig_rv", 32'(redirect_valid), 32'd0);
      return;
    end

    tick();
    garbage();
    redirect_ready = 1'($urandom_range(0, 1));
    sample();
    check("flush_xf", 32'(excp_flush), 32'(!only_ertn));
    check("flush_ef", 32'(ertn_flush), 32'(only_ertn));
    check("flush_rv", 32'(redirect_valid), 32'd0);
    check("flush_stall", 32'(commit_stall), 32'd1);
    if (!only_ertn) begin
      last_ec = ec; last_es = es; last_era = pc;
    end
    check("flush_ec", 32'(ecode_out), 32'(last_ec));
    check("flush_es", 32'(esubcode_out), 32'(last_es));
    check("flush_era", era_out, last_era);
`ifdef EXCP_BADV_EN
    begin
      bit bw;
      bw = !only_ertn && (fb == 0 || fb == 4 || fb == 5);
      check("flush_bwe", 32'(badv_we), 32'(bw));
      if (bw) check("flush_bv", badv_out, (fb == 0) ? pc : va);
    end
`endif

    for (int d = 0; d <= delay; d++) begin
      tick();
      garbage();
      redirect_ready = (d == delay);
      sample();
      check("redir_rv", 32'(redirect_valid), 32'd1);
      check("redir_pc", redirect_pc, tgt);
      check("redir_stall", 32'(commit_stall), 32'd1);
      check("redir_noflush", 32'(excp_flush | ertn_flush), 32'd0);
    end

    tick();
    idle_inputs();
    sample();
    check("post_rv", 32'(redirect_valid), 32'd0);
    check("post_stall", 32'(commit_stall), 32'd0);
  endtask

  task automatic check_output(input string tag);
    check({tag, "_rv"}, 32'(redirect_valid), 32'd0);
    check({tag, "_xf"}, 32'(excp_flush | ertn_flush), 32'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    last_ec = '0; last_es = '0; last_era = '0;
    tick();
    tick();
    reset = 1'b0;
    sample();
    check_all_zero("reset");

    // Interrupt with no commit must not act.
    tick();
    has_int = 1'b1;
    sample();
    check("int_nocommit_stall", 32'(commit_stall), 32'd0);
    tick();
    idle_inputs();
    sample();
    check_output("int_nocommit");

    // Reserved flag alone does not trigger.
    apply_stimulus(32'h1000, 7'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);

    // Directed scenarios.
    apply_stimulus(32'h1C00_0100, 7'h04, 1'b0, 1'b0, 32'h1C00_8040, 32'h0, 32'h0, 0);
    apply_stimulus(32'h0000_0200, 7'h20, 1'b0, 1'b1, 32'h1C00_8040, 32'h0, 32'h0, 1);
    apply_stimulus(32'h1C00_0500, 7'h00, 1'b1, 1'b0, 32'h1C00_8040, 32'h1C00_0404, 32'h0, 0);
    apply_stimulus(32'h1C00_0600, 7'h02, 1'b1, 1'b0, 32'h1C00_807F, 32'h1C00_0404, 32'h0, 5);
    apply_stimulus(32'h0000_3000, 7'h10, 1'b0, 1'b0, 32'h1C00_8000, 32'h0, 32'h1003, 0);
    apply_stimulus(32'h0000_3004, 7'h02, 1'b0, 1'b0, 32'h1C00_8000, 32'h0, 32'h2000, 0);
    apply_stimulus(32'h0000_3008, 7'h21, 1'b0, 1'b0, 32'h1C00_8000, 32'h0, 32'h2004, 0);

    // Reset while redirecting aborts the sequence.
    tick();
    commit_valid = 1'b1; commit_pc = 32'h1C00_0100; commit_excp = 7'h04;
    csr_eentry = 32'h1C00_8040;
    tick();
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    check_all_zero("rst_redir");
    last_ec = '0; last_es = '0; last_era = '0;
    apply_stimulus(32'h1C00_0700, 7'h08, 1'b0, 1'b0, 32'h1C00_9000, 32'h0, 32'h0, 2);

    // Reset in the flush cycle: no pulse afterwards and no redirect.
    tick();
    commit_valid = 1'b1; commit_pc = 32'h1C00_0800; commit_excp = 7'h02;
    csr_eentry = 32'h1C00_A000;
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    check_all_zero("rst_flush");
    last_ec = '0; last_es = '0; last_era = '0;
    tick();
    sample();
    check_output("rst_flush_after");

    // Random transactions.
    for (int n = 0; n < 60; n++) begin
      logic [6:0] ex;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0)      ex = 7'h00;
      else if (sel == 1) ex = 7'(1 << $urandom_range(0, 6));
      else               ex = 7'($urandom);
      apply_stimulus($urandom, ex, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                     $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
